tb_capture_controller: RTL
==========================

# tb_capture_controller

Sequencing controller for the circular trace buffer's dual-port RAM. It arms tracing, drives the port-A write address and enable, freezes capture a programmable number of writes after a trigger, and then dumps the captured window oldest-first through port B as a valid/ready stream. It sits between the filter/vector pipeline, which produces `valid_in`, and the host readback path.

## Interface
- `TB_SIZE`, 64: buffer depth in entries; power of two, ≥ 4.
- `POST_TRIGGER`, 32: writes still accepted after the trigger cycle; range 0..TB_SIZE.
- `MEM_WIDTH`, 256: RAM word width (N*DATA_WIDTH).
- `RAM_LATENCY`, 1: port-B read latency in cycles; ≥ 1.

Ports:
- `clk` in 1: clock.
- `rst` in 1: asynchronous, active-high reset.
- `arm` in 1: pulse; clears the buffer state and starts tracing.
- `trigger` in 1: trigger event; sampled only in TRACE.
- `valid_in` in 1: upstream vector valid.
- `dump_req` in 1: pulse; starts readback.
- `out_ready` in 1: readback consumer ready.
- `rd_data` in MEM_WIDTH: RAM port-B q.
- `tracing` out 1: asserted in TRACE or POST.
- `wr_en` out 1: RAM port-A write enable.
- `wr_addr` out $clog2(TB_SIZE): RAM port-A address.
- `rd_addr` out $clog2(TB_SIZE): RAM port-B address.
- `out_valid`, `out_last` out 1: readback stream valid and final-beat flag.
- `out_data` out MEM_WIDTH: readback data, equal to `rd_data`.
- `captured` out 1: a frozen window is available.
- `fill_count` out $clog2(TB_SIZE)+1: valid entries; saturates at TB_SIZE.

## Operation
- States are IDLE, TRACE, POST, DUMP_WAIT and DUMP_OUT. Reset enters IDLE.
- **Reset values:** all outputs are 0, all pointers and counters are 0, and `captured` is 0.
- **IDLE:**
  - `arm` clears `wr_addr`, `fill_count` and `captured`, then goes to TRACE.
  - `dump_req` with `fill_count`>0 loads `rd_addr` with the start address and a remaining count of `fill_count`, then goes to DUMP_WAIT.
  - When `arm` and `dump_req` are both asserted, `arm` wins.
- **TRACE and POST:**
  - `wr_en = valid_in & tracing`.
  - Each write increments `wr_addr` modulo TB_SIZE, wrapping from TB_SIZE-1 to 0.
  - Each write increments `fill_count`, saturating at TB_SIZE.
- **Trigger handling:**
  - `trigger` in TRACE loads the post counter with POST_TRIGGER. The trigger-cycle write, if any, still happens.
  - If POST_TRIGGER is 0, go to IDLE with `captured`=1. Otherwise go to POST.
  - In POST each write decrements the counter. The write that takes it to 0 is the last one; the controller then goes to IDLE with `captured`=1.
  - `trigger` in POST is ignored.
- **Re-arm:** `arm` in TRACE or POST restarts, exactly as it does in IDLE.
- **Dump start address:** `wr_addr` if `fill_count`==TB_SIZE, else 0.
- **DUMP_WAIT:** waits RAM_LATENCY cycles, then goes to DUMP_OUT.
- **DUMP_OUT:**
  - `out_valid`=1 and `rd_addr` is held stable.
  - `out_last`=1 when remaining==1.
  - On `out_valid & out_ready` with `out_last`=1: go to IDLE.
  - On `out_valid & out_ready` otherwise: `rd_addr`+1 with wrap, remaining−1, go to DUMP_WAIT.
- `captured` and `fill_count` persist after a dump, so the window can be re-dumped.
- In DUMP_WAIT and DUMP_OUT, `arm`, `trigger`, `dump_req` and `valid_in` are all ignored; `wr_en`=0.

## Timing
- `wr_en` and `out_data` are combinational. All other outputs are registered.
- The write for a `valid_in` in cycle t uses the `wr_addr` present in cycle t. `wr_addr` updates at t+1.
- `arm` sampled at edge k: `tracing`=1 from k+1.
- The first readback beat has `out_valid` RAM_LATENCY+1 cycles after the `dump_req` edge.
- Throughput is one beat per RAM_LATENCY+1 cycles, excluding stall cycles.
- **Backpressure:** `out_valid` stays high, and `rd_addr` and `out_data` stay stable, until `out_ready`.
- **Reset mid-operation:** `rst` at any point, including mid-dump, immediately forces IDLE and zeroes all outputs. The consumer discards any partial stream.

## Structure
- Shared package `tb_pkg`:
  - state enum `tb_state_t`.
  - `TB_ADDR_W` = $clog2(TB_SIZE).
- One FSM module plus pointer/counter logic; no sub-modules.
- The bench instantiates this block with the existing dual-port RAM: `wr_addr`/`wr_en` drive port A, `rd_addr` drives port B, and `rd_data` is taken from q_b.

## Test plan
All scenarios use TB_SIZE=8, POST_TRIGGER=3, RAM_LATENCY=1, and write data equal to the write index.
1. Hold `rst` 3 cycles, then release. Required: every output is 0 and `captured`=0. Pulse `dump_req`: required to be ignored, `out_valid` stays 0.
2. `arm`; 13 consecutive writes (indices 0..12) with `trigger` on write 9. Required:
   - `tracing` drops after write 12; `captured`=1; `fill_count`=8; `wr_addr`=5.
   - `dump_req` then yields data 5..12 from addresses 5,6,7,0,1,2,3,4.
   - `out_last` only on beat 12.
3. `arm`; 3 writes; `trigger` with `valid_in`=0; 3 more writes. Required: `fill_count`=6, dump yields data 0..5 from addresses 0..5, `out_last` on data 5.
4. During a dump, drop `out_ready` for 4 cycles on beat 2. Required: `out_valid`=1 and `rd_addr`/`out_data` unchanged; the stream resumes with no loss or duplication.
5. Assert `rst` mid-dump (beat 3). Required: `out_valid`=0 and `captured`=0 immediately. A following `dump_req` is ignored.
6. Pulse `arm` during DUMP_OUT. Required: ignored. Then `arm` in TRACE after 5 writes: required `fill_count`=0, `wr_addr`=0. `trigger` in POST: required to have no effect on the stop point.

Source files
------------

// File: rtl/tb_pkg.sv
// Shared types for the trace-buffer capture controller.
package tb_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_TRACE,
        ST_POST,
        ST_DUMP_WAIT,
        ST_DUMP_OUT
    } tb_state_t;

    // Address width for the default 64-entry buffer; instances derive their own.
    localparam int TB_SIZE_DEFAULT = 64;
    localparam int TB_ADDR_W       = $clog2(TB_SIZE_DEFAULT);

    function automatic logic is_tracing(input tb_state_t s);
        return (s == ST_TRACE) || (s == ST_POST);
    endfunction

endpackage

// File: rtl/tb_capture_controller.sv
// Capture/readback sequencer for the circular trace buffer: drives RAM port A while
// tracing, freezes after the post-trigger window, then streams it out oldest-first.
module tb_capture_controller
    import tb_pkg::*;
#(
    parameter int TB_SIZE      = 64,
    parameter int POST_TRIGGER = 32,
    parameter int MEM_WIDTH    = 256,
    parameter int RAM_LATENCY  = 1
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       arm,
    input  logic                       trigger,
    input  logic                       valid_in,
    input  logic                       dump_req,
    input  logic                       out_ready,
    input  logic [MEM_WIDTH-1:0]       rd_data,
    output logic                       tracing,
    output logic                       wr_en,
    output logic [$clog2(TB_SIZE)-1:0] wr_addr,
    output logic [$clog2(TB_SIZE)-1:0] rd_addr,
    output logic                       out_valid,
    output logic                       out_last,
    output logic [MEM_WIDTH-1:0]       out_data,
    output logic                       captured,
    output logic [$clog2(TB_SIZE):0]   fill_count
);

    localparam int ADDR_W = $clog2(TB_SIZE);
    localparam int CNT_W  = ADDR_W + 1;
    localparam int WAIT_W = (RAM_LATENCY > 1) ? $clog2(RAM_LATENCY) : 1;

    localparam logic [CNT_W-1:0]  FULL      = CNT_W'(TB_SIZE);
    localparam logic [CNT_W-1:0]  POST_LOAD = CNT_W'(POST_TRIGGER);
    localparam logic [WAIT_W-1:0] WAIT_LOAD = WAIT_W'(RAM_LATENCY - 1);

    tb_state_t          state_q,      state_d;
    logic [ADDR_W-1:0]  wr_addr_q,    wr_addr_d;
    logic [ADDR_W-1:0]  rd_addr_q,    rd_addr_d;
    logic [CNT_W-1:0]   fill_count_q, fill_count_d;
    logic [CNT_W-1:0]   remaining_q,  remaining_d;
    logic [CNT_W-1:0]   post_cnt_q,   post_cnt_d;
    logic [WAIT_W-1:0]  wait_q,       wait_d;
    logic               captured_q,   captured_d;
    logic               tracing_q,    tracing_d;
    logic               out_valid_q,  out_valid_d;
    logic               out_last_q,   out_last_d;

    assign wr_en = valid_in & tracing_q;

    always_comb begin
        // NOTE: every signal gets a default before the case so no path leaves
        // one unassigned, which would otherwise infer a latch.
        state_d      = state_q;
        wr_addr_d    = wr_addr_q;
        rd_addr_d    = rd_addr_q;
        fill_count_d = fill_count_q;
        remaining_d  = remaining_q;
        post_cnt_d   = post_cnt_q;
        wait_d       = wait_q;
        captured_d   = captured_q;

        unique case (state_q)
            ST_IDLE: begin
                if (arm) begin
                    wr_addr_d    = '0;
                    fill_count_d = '0;
                    post_cnt_d   = '0;
                    captured_d   = 1'b0;
                    state_d      = ST_TRACE;
                end else if (dump_req && fill_count_q != '0) begin
                    // Once the ring has wrapped, the oldest entry sits at the write pointer.
                    rd_addr_d   = (fill_count_q == FULL) ? wr_addr_q : '0;
                    remaining_d = fill_count_q;
                    wait_d      = WAIT_LOAD;
                    state_d     = ST_DUMP_WAIT;
                end
            end

            ST_TRACE, ST_POST: begin
                if (arm) begin
                    wr_addr_d    = '0;
                    fill_count_d = '0;
                    post_cnt_d   = '0;
                    captured_d   = 1'b0;
                    state_d      = ST_TRACE;
                end else begin
                    if (wr_en) begin
                        wr_addr_d = wr_addr_q + 1'b1;
                        if (fill_count_q != FULL) begin
                            fill_count_d = fill_count_q + 1'b1;
                        end
                    end
                    if (state_q == ST_TRACE) begin
                        if (trigger) begin
                            post_cnt_d = POST_LOAD;
                            if (POST_TRIGGER == 0) begin
                                captured_d = 1'b1;
                                state_d    = ST_IDLE;
                            end else begin
                                state_d    = ST_POST;
                            end
                        end
                    end else if (wr_en) begin
                        post_cnt_d = post_cnt_q - 1'b1;
                        if (post_cnt_q == CNT_W'(1)) begin
                            captured_d = 1'b1;
                            state_d    = ST_IDLE;
                        end
                    end
                end
            end

            ST_DUMP_WAIT: begin
                if (wait_q == '0) begin
                    state_d = ST_DUMP_OUT;
                end else begin
                    wait_d = wait_q - 1'b1;
                end
            end

            ST_DUMP_OUT: begin
                if (out_ready) begin
                    if (remaining_q == CNT_W'(1)) begin
                        state_d = ST_IDLE;
                    end else begin
                        rd_addr_d   = rd_addr_q + 1'b1;
                        remaining_d = remaining_q - 1'b1;
                        wait_d      = WAIT_LOAD;
                        state_d     = ST_DUMP_WAIT;
                    end
                end
            end

            default: state_d = ST_IDLE;
        endcase

        tracing_d   = is_tracing(state_d);
        out_valid_d = (state_d == ST_DUMP_OUT);
        out_last_d  = out_valid_d && (remaining_d == CNT_W'(1));
    end

    always_ff @(posedge clk or posedge rst) begin
        // NOTE: sequential state uses non-blocking assignments so every flop
        // samples the pre-edge values, independent of statement order.
        if (rst) begin
            state_q      <= ST_IDLE;
            wr_addr_q    <= '0;
            rd_addr_q    <= '0;
            fill_count_q <= '0;
            remaining_q  <= '0;
            post_cnt_q   <= '0;
            wait_q       <= '0;
            captured_q   <= 1'b0;
            tracing_q    <= 1'b0;
            out_valid_q  <= 1'b0;
            out_last_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            wr_addr_q    <= wr_addr_d;
            rd_addr_q    <= rd_addr_d;
            fill_count_q <= fill_count_d;
            remaining_q  <= remaining_d;
            post_cnt_q   <= post_cnt_d;
            wait_q       <= wait_d;
            captured_q   <= captured_d;
            tracing_q    <= tracing_d;
            out_valid_q  <= out_valid_d;
            out_last_q   <= out_last_d;
        end
    end

    assign tracing    = tracing_q;
    assign wr_addr    = wr_addr_q;
    assign rd_addr    = rd_addr_q;
    assign fill_count = fill_count_q;
    assign captured   = captured_q;
    assign out_valid  = out_valid_q;
    assign out_last   = out_last_q;
    // Gated so the stream reads zero outside a beat, including straight out of reset.
    assign out_data   = out_valid_q ? rd_data : '0;

endmodule
